lfsr_checker: RTL and testbench

Receive-side companion to the LFSR generator. Accepts a stream of NUM_BITS-wide LFSR states, locks onto the sequence from any valid starting state, then predicts each following word and flags mismatches. Sits at the sink end of a link or loopback driven by the generator. Reports lock status, per-word error pulses, a saturating error count and a sequence-wrap pulse.

---
 rtl/lfsr_checker.sv | 157 +++++++++++++++
 tb/tb_lfsr_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Locks onto an incoming XNOR-LFSR word stream, predicts each
//               next word and reports mismatches, lock status and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int NUM_BITS   = 3,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Data_DV,
    input  logic [NUM_BITS-1:0]  i_Data,
    output logic                 o_Locked,
    output logic                 o_Error,
    output logic [CNT_WIDTH-1:0] o_Err_Count,
    output logic                 o_Wrap,
    output logic [NUM_BITS-1:0]  o_Expected
);

    // Tap positions expressed as a bit mask over an 8-bit word.
    localparam logic [7:0] c_TAP_MASK8 =
        (NUM_BITS == 3) ? 8'h06 :
        (NUM_BITS == 4) ? 8'h0C :
        (NUM_BITS == 5) ? 8'h14 :
        (NUM_BITS == 6) ? 8'h30 :
        (NUM_BITS == 7) ? 8'h60 : 8'hB8;
    localparam logic [NUM_BITS-1:0] c_TAP_MASK = c_TAP_MASK8[NUM_BITS-1:0];
    localparam logic [3:0] c_LOCK_COUNT = 4'(LOCK_COUNT);
    localparam logic [3:0] c_LOSS_COUNT = 4'(LOSS_COUNT);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    function automatic logic [NUM_BITS-1:0] f_next(input logic [NUM_BITS-1:0] x);
        return {x[NUM_BITS-2:0], ~^(x & c_TAP_MASK)};
    endfunction

    state_t                r_state_q, w_state_d;
    logic [NUM_BITS-1:0]   r_ref_q, w_ref_d;
    logic [NUM_BITS-1:0]   r_exp_q, w_exp_d;
    logic [3:0]            r_match_q, w_match_d;
    logic [3:0]            r_miss_q, w_miss_d;
    logic                  r_locked_q, w_locked_d;
    logic                  r_error_q, w_error_d;
    logic                  r_wrap_q, w_wrap_d;
    logic [CNT_WIDTH-1:0]  r_err_cnt_q, w_err_cnt_d;

    logic                  w_is_lockup;
    logic                  w_hit;
    logic [3:0]            w_match_inc;
    logic [3:0]            w_miss_inc;

    assign w_is_lockup = (i_Data == {NUM_BITS{1'b1}});
    assign w_hit       = (i_Data == r_exp_q);
    assign w_match_inc = r_match_q + 4'd1;
    assign w_miss_inc  = r_miss_q + 4'd1;

    always_comb begin
        w_state_d   = r_state_q;
        w_ref_d     = r_ref_q;
        w_exp_d     = r_exp_q;
        w_match_d   = r_match_q;
        w_miss_d    = r_miss_q;
        w_error_d   = 1'b0;
        w_wrap_d    = 1'b0;
        w_err_cnt_d = r_err_cnt_q;
        if (i_Data_DV) begin
            case (r_state_q)
                S_HUNT: begin
                    if (!w_is_lockup) begin
                        w_ref_d   = i_Data;
                        w_exp_d   = f_next(i_Data);
                        w_match_d = 4'd0;
                        w_state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        w_exp_d   = f_next(i_Data);
                        w_match_d = w_match_inc;
                        if (w_match_inc == c_LOCK_COUNT) begin
                            w_state_d = S_LOCKED;
                            w_miss_d  = 4'd0;
                        end
                    end else if (!w_is_lockup) begin
                        w_ref_d   = i_Data;
                        w_exp_d   = f_next(i_Data);
                        w_match_d = 4'd0;
                    end else begin
                        w_state_d = S_HUNT;
                    end
                end
                S_LOCKED: begin
                    if (w_hit) begin
                        w_exp_d  = f_next(i_Data);
                        w_miss_d = 4'd0;
                        w_wrap_d = (i_Data == r_ref_q);
                    end else begin
                        // Flywheel: keep advancing the prediction, ignore the bad word.
                        w_error_d = 1'b1;
                        if (r_err_cnt_q != c_CNT_MAX) begin
                            w_err_cnt_d = r_err_cnt_q + CNT_WIDTH'(1);
                        end
                        w_exp_d  = f_next(r_exp_q);
                        w_miss_d = w_miss_inc;
                        if (w_miss_inc == c_LOSS_COUNT) begin
                            w_state_d = S_HUNT;
                        end
                    end
                end
                default: w_state_d = S_HUNT;
            endcase
        end
        w_locked_d = (w_state_d == S_LOCKED);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state_q   <= S_HUNT;
            r_ref_q     <= '0;
            r_exp_q     <= '0;
            r_match_q   <= 4'd0;
            r_miss_q    <= 4'd0;
            r_locked_q  <= 1'b0;
            r_error_q   <= 1'b0;
            r_wrap_q    <= 1'b0;
            r_err_cnt_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_ref_q     <= w_ref_d;
            r_exp_q     <= w_exp_d;
            r_match_q   <= w_match_d;
            r_miss_q    <= w_miss_d;
            r_locked_q  <= w_locked_d;
            r_error_q   <= w_error_d;
            r_wrap_q    <= w_wrap_d;
            r_err_cnt_q <= w_err_cnt_d;
        end
    end

    assign o_Locked    = r_locked_q;
    assign o_Error     = r_error_q;
    assign o_Err_Count = r_err_cnt_q;
    assign o_Wrap      = r_wrap_q;
    assign o_Expected  = r_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Self-checking bench: vector table, corner sequences and a
//               randomized run against a behavioural model of the checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

    localparam int c_NB   = 3;
    localparam int c_LOCK = 4;
    localparam int c_LOSS = 2;
    localparam int c_CW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            dv;
    logic [c_NB-1:0] data;
    logic            locked, error, wrap;
    logic [c_CW-1:0] err_count;
    logic [c_NB-1:0] expected;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    lfsr_checker #(
        .NUM_BITS   (c_NB),
        .LOCK_COUNT (c_LOCK),
        .LOSS_COUNT (c_LOSS),
        .CNT_WIDTH  (c_CW)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Data_DV   (dv),
        .i_Data      (data),
        .o_Locked    (locked),
        .o_Error     (error),
        .o_Err_Count (err_count),
        .o_Wrap      (wrap),
        .o_Expected  (expected)
    );

    // Behavioural model: mode 0 = hunting, 1 = checking, 2 = locked.
    int m_mode, m_ref, m_exp, m_matches, m_misses, m_err, m_error, m_wrap;
    int taps[$] = '{2, 1};

    function automatic int lfsr_next(input int x);
        int fb = 1;
        foreach (taps[k]) fb = fb ^ ((x >> taps[k]) & 1);
        return ((x * 2) % (1 << c_NB)) + fb;
    endfunction

    task automatic model_step(input int r, input int v, input int w);
        int ones = (1 << c_NB) - 1;
        m_error = 0;
        m_wrap  = 0;
        if (r != 0) begin
            m_mode = 0; m_ref = 0; m_exp = 0; m_matches = 0; m_misses = 0; m_err = 0;
        end else if (v != 0) begin
            if (m_mode == 0) begin
                if (w != ones) begin
                    m_ref = w; m_exp = lfsr_next(w); m_matches = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (w == m_exp) begin
                    m_exp = lfsr_next(w);
                    m_matches++;
                    if (m_matches == c_LOCK) begin m_mode = 2; m_misses = 0; end
                end else if (w != ones) begin
                    m_ref = w; m_exp = lfsr_next(w); m_matches = 0;
                end else begin
                    m_mode = 0;
                end
            end else begin
                if (w == m_exp) begin
                    m_exp = lfsr_next(w); m_misses = 0;
                    if (w == m_ref) m_wrap = 1;
                end else begin
                    m_error = 1;
                    if (m_err < (1 << c_CW) - 1) m_err++;
                    m_exp = lfsr_next(m_exp);
                    m_misses++;
                    if (m_misses == c_LOSS) m_mode = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, compare all outputs.
    task automatic cycle(input logic r, input logic v, input logic [c_NB-1:0] w);
        rst = r; dv = v; data = w;
        @(posedge clk);
        #1;
        model_step(int'(r), int'(v), int'(w));
        check("model_locked",   int'(locked),    (m_mode == 2) ? 1 : 0);
        check("model_error",    int'(error),     m_error);
        check("model_wrap",     int'(wrap),      m_wrap);
        check("model_errcount", int'(err_count), m_err);
        check("model_expected", int'(expected),  m_exp);
    endtask

    typedef struct {
        logic            rst;
        logic            dv;
        logic [c_NB-1:0] data;
        logic            locked;
        logic            error;
        logic            wrap;
        logic [c_CW-1:0] cnt;
        logic [c_NB-1:0] expv;
    } vec_t;

    vec_t vecs[26];

    initial begin
        logic [c_NB-1:0] seq[5];
        logic            p_locked;
        logic [c_NB-1:0] p_exp;
        logic [c_NB-1:0] w;

        //         rst dv dat  L  E  W  cnt exp
        vecs[0]  = '{1, 0, 0,  0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 6,  0, 0, 0, 0, 5};
        vecs[2]  = '{0, 1, 5,  0, 0, 0, 0, 2};
        vecs[3]  = '{0, 1, 2,  0, 0, 0, 0, 4};
        vecs[4]  = '{0, 1, 4,  0, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0,  1, 0, 0, 0, 1};
        vecs[6]  = '{0, 1, 1,  1, 0, 0, 0, 3};
        vecs[7]  = '{0, 1, 3,  1, 0, 0, 0, 6};
        vecs[8]  = '{0, 1, 6,  1, 0, 1, 0, 5};
        vecs[9]  = '{0, 0, 3,  1, 0, 0, 0, 5};
        vecs[10] = '{0, 1, 5,  1, 0, 0, 0, 2};
        vecs[11] = '{0, 1, 2,  1, 0, 0, 0, 4};
        vecs[12] = '{0, 1, 4,  1, 0, 0, 0, 0};
        vecs[13] = '{0, 1, 0,  1, 0, 0, 0, 1};
        vecs[14] = '{0, 1, 7,  1, 1, 0, 1, 3};
        vecs[15] = '{0, 1, 3,  1, 0, 0, 1, 6};
        vecs[16] = '{0, 1, 6,  1, 0, 1, 1, 5};
        vecs[17] = '{0, 1, 5,  1, 0, 0, 1, 2};
        vecs[18] = '{0, 1, 2,  1, 0, 0, 1, 4};
        vecs[19] = '{0, 1, 4,  1, 0, 0, 1, 0};
        vecs[20] = '{0, 1, 0,  1, 0, 0, 1, 1};
        vecs[21] = '{0, 1, 5,  1, 1, 0, 2, 3};
        vecs[22] = '{0, 1, 5,  0, 1, 0, 3, 6};
        vecs[23] = '{0, 0, 0,  0, 0, 0, 3, 6};
        vecs[24] = '{0, 1, 7,  0, 0, 0, 3, 6};
        vecs[25] = '{0, 1, 6,  0, 0, 0, 3, 5};

        rst = 1'b1; dv = 1'b0; data = '0;
        m_mode = 0; m_ref = 0; m_exp = 0; m_matches = 0; m_misses = 0; m_err = 0;
        m_error = 0; m_wrap = 0;
        cycle(1'b1, 1'b0, '0);

        // Lock, wrap, single error with flywheel, loss of lock, rehunt.
        for (int i = 0; i < 26; i++) begin
            cycle(vecs[i].rst, vecs[i].dv, vecs[i].data);
            check($sformatf("vec%0d_locked", i),   int'(locked),    int'(vecs[i].locked));
            check($sformatf("vec%0d_error", i),    int'(error),     int'(vecs[i].error));
            check($sformatf("vec%0d_wrap", i),     int'(wrap),      int'(vecs[i].wrap));
            check($sformatf("vec%0d_errcount", i), int'(err_count), int'(vecs[i].cnt));
            check($sformatf("vec%0d_expected", i), int'(expected),  int'(vecs[i].expv));
        end

        // Lockup rejection then reseed.
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 3'd7);
        check("lockup_expected_held", int'(expected), 0);
        cycle(1'b0, 1'b1, 3'd6);
        cycle(1'b0, 1'b1, 3'd2);
        check("reseed_expected", int'(expected), 4);
        check("reseed_unlocked", int'(locked), 0);
        cycle(1'b0, 1'b1, 3'd4);
        cycle(1'b0, 1'b1, 3'd0);
        cycle(1'b0, 1'b1, 3'd1);
        check("reseed_not_yet", int'(locked), 0);
        cycle(1'b0, 1'b1, 3'd3);
        check("reseed_lock", int'(locked), 1);

        // DV gaps: idle cycles must not move any output.
        cycle(1'b1, 1'b0, '0);
        seq = '{3'd6, 3'd5, 3'd2, 3'd4, 3'd0};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, seq[i]);
            p_locked = locked; p_exp = expected;
            for (int j = 0; j < 2; j++) begin
                cycle(1'b0, 1'b0, 3'(j + i));
                check("gap_locked_hold", int'(locked), int'(p_locked));
                check("gap_exp_hold", int'(expected), int'(p_exp));
            end
        end
        check("gap_locked", int'(locked), 1);
        check("gap_expected", int'(expected), 1);

        // Build an error count of 3 while staying locked, then reset with DV.
        seq = '{3'd7, 3'd3, 3'd7, 3'd5, 3'd7};
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, seq[i]);
        cycle(1'b0, 1'b1, 3'd4);
        check("pre_reset_count", int'(err_count), 3);
        check("pre_reset_locked", int'(locked), 1);
        cycle(1'b1, 1'b1, 3'd1);
        check("rst_locked", int'(locked), 0);
        check("rst_count", int'(err_count), 0);
        check("rst_expected", int'(expected), 0);
        seq = '{3'd0, 3'd1, 3'd3, 3'd6, 3'd5};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, seq[i]);
            check($sformatf("relock_w%0d", i), int'(locked), (i == 4) ? 1 : 0);
        end

        // Randomized run, biased toward the predicted word so lock occurs.
        for (int i = 0; i < 3000; i++) begin
            w = ($urandom_range(0, 4) != 0) ? 3'(m_exp) : 3'($urandom_range(0, 7));
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
